// File: rtl/alu_iter_if.sv
// Request/response bundle between the execute-stage sequencer and the iterative ALU.
interface alu_iter_if;
   logic        start;
   logic [15:0] InA;
   logic [15:0] InB;
   logic        Cin;
   logic [2:0]  Op;
   logic        invA;
   logic        invB;
   logic        sign;
   logic        busy;
   logic        done;
   logic [15:0] Out;
   logic        Ofl;
   logic        Zero;

   modport master (
      output start, InA, InB, Cin, Op, invA, invB, sign,
      input  busy, done, Out, Ofl, Zero
   );

   modport slave (
      input  start, InA, InB, Cin, Op, invA, invB, sign,
      output busy, done, Out, Ofl, Zero
   );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle 16-bit ALU: single-cycle add/logic ops, shifts and rotates
// advance one bit position per clock.
module alu_iter (
   input  logic       clk,
   input  logic       rst,
   alu_iter_if.slave  bus
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] work_q, work_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] out_q, out_d;
   logic        ofl_q, ofl_d;
   logic        zero_q, zero_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;

   logic [15:0] eff_a_s, eff_b_s;
   logic [3:0]  k_s;
   logic [16:0] alu_res_s;

   // Result {ofl, value} of the single-cycle group, selected by Op[1:0].
   function automatic logic [16:0] alu_op(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin,
                                          input logic sgn);
      logic [16:0] sum;
      logic        ofl;
      sum = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
      ofl = sgn ? (sum[16] ^ sum[15] ^ a[15] ^ b[15]) : sum[16];
      case (op)
         2'b00:   alu_op = {ofl, sum[15:0]};
         2'b01:   alu_op = {1'b0, a & b};
         2'b10:   alu_op = {1'b0, a | b};
         2'b11:   alu_op = {1'b0, a ^ b};
         default: alu_op = 17'h00000;
      endcase
   endfunction

   // One-position step of the shift group: rotl, shl, sra, srl.
   function automatic logic [15:0] shift1(input logic [1:0] op, input logic [15:0] v);
      case (op)
         2'b00:   shift1 = {v[14:0], v[15]};
         2'b01:   shift1 = {v[14:0], 1'b0};
         2'b10:   shift1 = {v[15], v[15:1]};
         2'b11:   shift1 = {1'b0, v[15:1]};
         default: shift1 = v;
      endcase
   endfunction

   assign eff_a_s   = bus.invA ? ~bus.InA : bus.InA;
   assign eff_b_s   = bus.invB ? ~bus.InB : bus.InB;
   assign k_s       = eff_b_s[3:0];
   assign alu_res_s = alu_op(bus.Op[1:0], eff_a_s, eff_b_s, bus.Cin, bus.sign);

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         work_q  <= 16'h0000;
         cnt_q   <= 4'd0;
         op_q    <= 2'b00;
         out_q   <= 16'h0000;
         ofl_q   <= 1'b0;
         zero_q  <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         out_q   <= out_d;
         ofl_q   <= ofl_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.Op[2] && (k_s != 4'd0)) begin
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == 4'd1) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values; results hold until the next completion.
   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      out_d  = out_q;
      ofl_d  = ofl_q;
      done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.Op[2]) begin
                  out_d  = alu_res_s[15:0];
                  ofl_d  = alu_res_s[16];
                  done_d = 1'b1;
               end else if (k_s == 4'd0) begin
                  out_d  = eff_a_s;
                  ofl_d  = 1'b0;
                  done_d = 1'b1;
               end else begin
                  work_d = eff_a_s;
                  cnt_d  = k_s;
                  op_d   = bus.Op[1:0];
               end
            end else begin
               done_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            work_d = shift1(op_q, work_q);
            cnt_d  = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               out_d  = work_d;
               ofl_d  = 1'b0;
               done_d = 1'b1;
            end else begin
               done_d = 1'b0;
            end
         end
         default: begin
            cnt_d  = 4'd0;
            done_d = 1'b0;
         end
      endcase
      zero_d = (out_d == 16'h0000);
      busy_d = (state_d == ST_SHIFT);
   end

   assign bus.Out  = out_q;
   assign bus.Ofl  = ofl_q;
   assign bus.Zero = zero_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_iter;
   logic clk;
   logic rst;
   int   errors;
   int   checks;
   logic [15:0] prev_out;

   alu_iter_if bus ();

   alu_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: returns {ofl, result} from the operation definitions.
   function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] ina,
                                         input logic [15:0] inb, input logic cin,
                                         input logic inva, input logic invb,
                                         input logic sgn);
      logic [15:0] a, b, r;
      int k, s, ss;
      logic ofl;
      a = inva ? ~ina : ina;
      b = invb ? ~inb : inb;
      k = int'(b[3:0]);
      ofl = 1'b0;
      r = 16'h0000;
      case (op)
         3'd0: r = (k == 0) ? a : ((a << k) | (a >> (16 - k)));
         3'd1: r = a << k;
         3'd2: r = 16'($signed(a) >>> k);
         3'd3: r = a >> k;
         3'd4: begin
            s  = int'(a) + int'(b) + int'(cin);
            ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
            r  = s[15:0];
            ofl = sgn ? ((ss > 32767) || (ss < -32768)) : (s > 65535);
         end
         3'd5: r = a & b;
         3'd6: r = a | b;
         default: r = a ^ b;
      endcase
      return {ofl, r};
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [15:0] inb,
                                    input logic invb);
      logic [15:0] b;
      b = invb ? ~inb : inb;
      if (op[2] || (b[3:0] == 4'd0)) return 1;
      return int'(b[3:0]) + 1;
   endfunction

   // Drives one request at the acceptance edge; returns in cycle N+1.
   task automatic issue(input logic [2:0] op, input logic [15:0] ina, input logic [15:0] inb,
                        input logic cin, input logic inva, input logic invb, input logic sgn);
      bus.Op = op; bus.InA = ina; bus.InB = inb; bus.Cin = cin;
      bus.invA = inva; bus.invB = invb; bus.sign = sgn;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.Out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", bus.Out); end
      checks++; if (bus.Ofl !== 1'b0) begin errors++; $display("FAIL reset_ofl got=%b exp=0", bus.Ofl); end
      checks++; if (bus.Zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", bus.Zero); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_rotl1();
      issue(3'd0, 16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL rotl_n1 busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rotl_n2 busy=%b done=%b exp busy=0 done=1", bus.busy, bus.done); end
      checks++; if (bus.Out !== 16'h0003 || bus.Zero !== 1'b0) begin errors++; $display("FAIL rotl_out got=%h zero=%b exp=0003 zero=0", bus.Out, bus.Zero); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rotl_pulse got=%b exp=0", bus.done); end
   endtask

   task automatic test_sra15();
      logic bad;
      bad = 1'b0;
      issue(3'd2, 16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad = 1'b1;
         if (bus.Out !== 16'h0003) bad = 1'b1;
         if (i == 5) begin
            bus.Op = 3'd4; bus.InA = 16'h0000; bus.InB = 16'h0000; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
      end
      checks++; if (bad) begin errors++; $display("FAIL sra_busy_window busy=%b done=%b out=%h exp busy=1 done=0 out=0003 throughout", bus.busy, bus.done, bus.Out); end
      checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL sra_done busy=%b done=%b exp busy=0 done=1", bus.busy, bus.done); end
      checks++; if (bus.Out !== 16'hFFFF) begin errors++; $display("FAIL sra_out got=%h exp=ffff", bus.Out); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL sra_ignored_start busy=%b done=%b exp 0 0", bus.busy, bus.done); end
   endtask

   task automatic test_add();
      issue(3'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL add_s_done got=%b exp=1", bus.done); end
      checks++; if (bus.Out !== 16'h8000 || bus.Ofl !== 1'b1 || bus.Zero !== 1'b0) begin errors++; $display("FAIL add_signed got=%h ofl=%b zero=%b exp=8000 1 0", bus.Out, bus.Ofl, bus.Zero); end
      issue(3'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.Out !== 16'h8000 || bus.Ofl !== 1'b0) begin errors++; $display("FAIL add_unsigned got=%h ofl=%b exp=8000 0", bus.Out, bus.Ofl); end
      issue(3'd4, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.Out !== 16'h0000 || bus.Ofl !== 1'b1 || bus.Zero !== 1'b1) begin errors++; $display("FAIL add_wrap got=%h ofl=%b zero=%b exp=0000 1 1", bus.Out, bus.Ofl, bus.Zero); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0 || bus.Out !== 16'h0000) begin errors++; $display("FAIL add_hold done=%b out=%h exp 0 0000", bus.done, bus.Out); end
   endtask

   task automatic test_back_to_back();
      issue(3'd5, 16'h00FF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (bus.done !== 1'b1 || bus.Out !== 16'hFF00 || bus.Ofl !== 1'b0) begin errors++; $display("FAIL and_inv done=%b got=%h ofl=%b exp 1 ff00 0", bus.done, bus.Out, bus.Ofl); end
      issue(3'd7, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.done !== 1'b1 || bus.Out !== 16'hFFFF) begin errors++; $display("FAIL xor_b2b done=%b got=%h exp 1 ffff", bus.done, bus.Out); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", bus.done); end
   endtask

   task automatic test_reset_mid();
      logic saw_done;
      saw_done = 1'b0;
      issue(3'd1, 16'h1234, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_ctl busy=%b done=%b exp 0 0", bus.busy, bus.done); end
      checks++; if (bus.Out !== 16'h0000 || bus.Zero !== 1'b1 || bus.Ofl !== 1'b0) begin errors++; $display("FAIL rstmid_out got=%h zero=%b ofl=%b exp 0000 1 0", bus.Out, bus.Zero, bus.Ofl); end
      for (int i = 0; i < 10; i++) begin
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (saw_done) begin errors++; $display("FAIL rstmid_dropped activity seen after reset, exp none"); end
      issue(3'd4, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.done !== 1'b1 || bus.Out !== 16'h0005) begin errors++; $display("FAIL rstmid_add done=%b got=%h exp 1 0005", bus.done, bus.Out); end
   endtask

   task automatic test_rst_start();
      rst = 1'b1;
      issue(3'd4, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      checks++; if (bus.done !== 1'b0 || bus.Out !== 16'h0000) begin errors++; $display("FAIL rst_start done=%b got=%h exp 0 0000", bus.done, bus.Out); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_start_late done=%b busy=%b exp 0 0", bus.done, bus.busy); end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [15:0] ina, inb;
      logic        cin, inva, invb, sgn, held;
      logic [16:0] exp;
      int          lat, cyc;
      prev_out = 16'h0000;
      for (int n = 0; n < 60; n++) begin
         op = 3'($urandom_range(0, 7)); ina = 16'($urandom); inb = 16'($urandom);
         cin = 1'($urandom); inva = 1'($urandom); invb = 1'($urandom); sgn = 1'($urandom);
         exp = model(op, ina, inb, cin, inva, invb, sgn);
         lat = model_lat(op, inb, invb);
         issue(op, ina, inb, cin, inva, invb, sgn);
         held = 1'b1;
         cyc = 1;
         while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.Out !== prev_out || bus.busy !== 1'b1) held = 1'b0;
            bus.InA = 16'($urandom); bus.InB = 16'($urandom); bus.invA = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
         end
         checks++; if (cyc != lat) begin errors++; $display("FAIL rnd_latency op=%0d got=%0d exp=%0d", op, cyc, lat); end
         checks++; if (!held) begin errors++; $display("FAIL rnd_hold op=%0d out=%h exp=%h during busy", op, bus.Out, prev_out); end
         checks++; if (bus.Out !== exp[15:0] || bus.Ofl !== exp[16] || bus.Zero !== (exp[15:0] == 16'h0000)) begin
            errors++; $display("FAIL rnd_result op=%0d a=%h b=%h got=%h ofl=%b zero=%b exp=%h ofl=%b", op, ina, inb, bus.Out, bus.Ofl, bus.Zero, exp[15:0], exp[16]);
         end
         prev_out = exp[15:0];
      end
   endtask

   initial begin
      errors = 0; checks = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.InA = 16'h0000; bus.InB = 16'h0000; bus.Cin = 1'b0;
      bus.Op = 3'd0; bus.invA = 1'b0; bus.invB = 1'b0; bus.sign = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_rotl1();
      test_sra15();
      test_add();
      test_back_to_back();
      test_reset_mid();
      test_rst_start();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
